// File: rtl/uart_cfg_ctrl_pkg.sv
// Shared UART configuration types, address map, legal limits and the per-write check.
// Imported by uart_cfg_regs and uart_cfg_ctrl.
package uart_config;

    // Config structs consumed by uart_tx, uart_rx and the baud generator.
    typedef struct packed {
        logic       parity_en;
        logic       parity_even;
        logic [3:0] data_len;
        logic [1:0] stop_len;
    } uart_config_trx;

    typedef struct packed {
        logic [7:0] divisor;
        logic [4:0] osm_rate;
    } uart_config_bdgen;

    typedef struct packed {
        logic [4:0] osm;
        logic [3:0] smp_nth;
    } uart_config_rx;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_QUIET,
        APPLY,
        SETTLE
    } cfg_states;

    localparam logic [1:0] ADDR_TRX   = 2'd0;
    localparam logic [1:0] ADDR_BDGEN = 2'd1;
    localparam logic [1:0] ADDR_RX    = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    localparam logic [3:0] DATA_LEN_MIN = 4'd5;
    localparam logic [3:0] DATA_LEN_MAX = 4'd8;
    localparam logic [4:0] OSM_MIN      = 5'd4;
    localparam logic [1:0] STOP_LEN_BAD = 2'd3;

    // Field-level legality of a single write; the reserved address is always accepted.
    function automatic logic cfg_valid(input logic [1:0] addr, input logic [12:0] data);
        logic ok;
        ok = 1'b1;
        case (addr)
            ADDR_TRX:   ok = (data[5:2] >= DATA_LEN_MIN) && (data[5:2] <= DATA_LEN_MAX) &&
                             (data[1:0] != STOP_LEN_BAD);
            ADDR_BDGEN: ok = (data[12:5] != 8'd0) && (data[4:0] >= OSM_MIN);
            ADDR_RX:    ok = (data[8:4] >= OSM_MIN);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/uart_cfg_regs.sv
// Shadow, staging and active UART configuration register sets plus write checking.
// The shadow is written by software, staging is loaded on commit, active is loaded on apply.
module uart_cfg_regs
    import uart_config::*;
#(
    parameter logic [7:0] DEF_DIVISOR = 8'd54,
    parameter logic [4:0] DEF_OSM     = 5'd16,
    parameter logic [3:0] DEF_SMP_NTH = 4'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [15:0]      wr_data,
    input  logic             load_stage,
    input  logic             apply,
    output logic             wr_err,
    output logic             stage_ok,
    output uart_config_trx   cfg_trx,
    output uart_config_bdgen cfg_bdgen,
    output uart_config_rx    cfg_rx
);

    localparam uart_config_trx   RST_TRX   = '{parity_en: 1'b0, parity_even: 1'b0,
                                               data_len: 4'd8, stop_len: 2'd0};
    localparam uart_config_bdgen RST_BDGEN = '{divisor: DEF_DIVISOR, osm_rate: DEF_OSM};
    localparam uart_config_rx    RST_RX    = '{osm: DEF_OSM, smp_nth: DEF_SMP_NTH};

    uart_config_trx   sh_trx_q, sh_trx_d, stg_trx_q;
    uart_config_bdgen sh_bdgen_q, sh_bdgen_d, stg_bdgen_q;
    uart_config_rx    sh_rx_q, sh_rx_d, stg_rx_q;
    logic             wr_ok;
    logic             wr_take;

    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[15:13];

    assign wr_ok   = cfg_valid(wr_addr, wr_data[12:0]);
    assign wr_err  = wr_en && !wr_ok;
    assign wr_take = wr_en && wr_ok;

    // Next shadow values include a same-cycle write so a commit snapshot sees it.
    always_comb begin
        sh_trx_d   = sh_trx_q;
        sh_bdgen_d = sh_bdgen_q;
        sh_rx_d    = sh_rx_q;
        if (wr_take) begin
            case (wr_addr)
                ADDR_TRX:   sh_trx_d   = uart_config_trx'(wr_data[7:0]);
                ADDR_BDGEN: sh_bdgen_d = uart_config_bdgen'(wr_data[12:0]);
                ADDR_RX:    sh_rx_d    = uart_config_rx'(wr_data[8:0]);
                default:    ;
            endcase
        end
    end

    assign stage_ok = ({1'b0, sh_rx_d.smp_nth} < sh_rx_d.osm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_trx_q    <= RST_TRX;
            sh_bdgen_q  <= RST_BDGEN;
            sh_rx_q     <= RST_RX;
            stg_trx_q   <= RST_TRX;
            stg_bdgen_q <= RST_BDGEN;
            stg_rx_q    <= RST_RX;
            cfg_trx     <= RST_TRX;
            cfg_bdgen   <= RST_BDGEN;
            cfg_rx      <= RST_RX;
        end else begin
            sh_trx_q   <= sh_trx_d;
            sh_bdgen_q <= sh_bdgen_d;
            sh_rx_q    <= sh_rx_d;
            if (load_stage) begin
                stg_trx_q   <= sh_trx_d;
                stg_bdgen_q <= sh_bdgen_d;
                stg_rx_q    <= sh_rx_d;
            end
            if (apply) begin
                cfg_trx   <= stg_trx_q;
                cfg_bdgen <= stg_bdgen_q;
                cfg_rx    <= stg_rx_q;
            end
        end
    end

endmodule

// File: rtl/uart_cfg_ctrl.sv
// UART configuration commit controller: waits for a quiet line, swaps staged config in atomically.
// Optional RX-wait timeout with rx_abort is enabled by defining UART_CFG_TIMEOUT_EN.
module uart_cfg_ctrl
    import uart_config::*;
#(
    parameter logic [7:0]  DEF_DIVISOR = 8'd54,
    parameter logic [4:0]  DEF_OSM     = 5'd16,
    parameter logic [3:0]  DEF_SMP_NTH = 4'd8,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [15:0]      wr_data,
    input  logic             commit,
    input  logic             tx_busy,
    input  logic             rx_busy,
    output uart_config_trx   cfg_trx,
    output uart_config_bdgen cfg_bdgen,
    output uart_config_rx    cfg_rx,
    output logic             tx_hold,
    output logic             bdgen_reload,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rx_abort
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

    cfg_states        state_q, state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             load_stage;
    logic             commit_rej;
    logic             settle_done;
    logic             wr_err;
    logic             stage_ok;
    logic             tmo_hit;
    logic             abort_err;
    logic             tx_hold_q, done_q, err_q;

    uart_cfg_regs #(
        .DEF_DIVISOR (DEF_DIVISOR),
        .DEF_OSM     (DEF_OSM),
        .DEF_SMP_NTH (DEF_SMP_NTH)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_stage (load_stage),
        .apply      (state_q == APPLY),
        .wr_err     (wr_err),
        .stage_ok   (stage_ok),
        .cfg_trx    (cfg_trx),
        .cfg_bdgen  (cfg_bdgen),
        .cfg_rx     (cfg_rx)
    );

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        load_stage  = 1'b0;
        commit_rej  = 1'b0;
        settle_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    if (stage_ok) begin
                        load_stage = 1'b1;
                        state_d    = WAIT_QUIET;
                    end else begin
                        commit_rej = 1'b1;
                    end
                end
            end
            WAIT_QUIET: begin
                if ((!tx_busy && !rx_busy) || tmo_hit) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == CNT_W'(SETTLE_CYC - 1)) begin
                    settle_done = 1'b1;
                    state_d     = IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            tx_hold_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            tx_hold_q <= (state_d != IDLE);
            done_q    <= settle_done;
            err_q     <= wr_err || commit_rej || (settle_done && abort_err);
        end
    end

`ifdef UART_CFG_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_q;
    logic             aborted_q;
    logic             rx_abort_q;

    // Only a TX-idle, RX-busy wait counts toward the timeout.
    assign tmo_hit = (state_q == WAIT_QUIET) && !tx_busy && rx_busy &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q      <= '0;
            aborted_q  <= 1'b0;
            rx_abort_q <= 1'b0;
        end else begin
            if ((state_q != WAIT_QUIET) || !rx_busy) begin
                tmo_q <= '0;
            end else if (!tx_busy) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (load_stage) begin
                aborted_q <= 1'b0;
            end else if (tmo_hit) begin
                aborted_q <= 1'b1;
            end
            rx_abort_q <= tmo_hit;
        end
    end

    assign rx_abort  = rx_abort_q;
    assign abort_err = aborted_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
    assign abort_err      = 1'b0;
    assign rx_abort       = 1'b0;
`endif

    assign tx_hold      = tx_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);
    assign bdgen_reload = (state_q == APPLY);

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_uart_cfg_ctrl;
    import uart_config::*;

    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_addr = 2'd0;
    logic [15:0]      wr_data = 16'd0;
    logic             commit = 1'b0;
    logic             tx_busy = 1'b0;
    logic             rx_busy = 1'b0;
    uart_config_trx   cfg_trx;
    uart_config_bdgen cfg_bdgen;
    uart_config_rx    cfg_rx;
    logic             tx_hold, bdgen_reload, busy, done, err, rx_abort;

    uart_cfg_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .tx_busy      (tx_busy),
        .rx_busy      (rx_busy),
        .cfg_trx      (cfg_trx),
        .cfg_bdgen    (cfg_bdgen),
        .cfg_rx       (cfg_rx),
        .tx_hold      (tx_hold),
        .bdgen_reload (bdgen_reload),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rx_abort     (rx_abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: register sets as raw field vectors, commit progress as edge numbers.
    logic [7:0]  sh_trx, stg_trx, act_trx;
    logic [12:0] sh_bd, stg_bd, act_bd;
    logic [8:0]  sh_rx, stg_rx, act_rx;
    bit          in_commit;
    int          edge_n = 0;
    int          quiet_edge;
    bit          x_err, x_done, x_reload;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    function automatic bit legal(input logic [1:0] a, input logic [15:0] d);
        case (a)
            2'd0: return (d[5:2] >= 4'd5) && (d[5:2] <= 4'd8) && (d[1:0] != 2'd3);
            2'd1: return (d[12:5] != 8'd0) && (d[4:0] >= 5'd4);
            2'd2: return d[8:4] >= 5'd4;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        sh_trx = 8'h20;    stg_trx = 8'h20;    act_trx = 8'h20;
        sh_bd  = {8'd54, 5'd16}; stg_bd = {8'd54, 5'd16}; act_bd = {8'd54, 5'd16};
        sh_rx  = {5'd16, 4'd8};  stg_rx = {5'd16, 4'd8};  act_rx = {5'd16, 4'd8};
        in_commit = 1'b0;
        quiet_edge = -1;
    endtask

    task automatic model_step();
        bit idle_before;
        edge_n++;
        x_err = 1'b0; x_done = 1'b0; x_reload = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        idle_before = !in_commit;
        if (in_commit) begin
            if (quiet_edge < 0) begin
                if (!tx_busy && !rx_busy) begin
                    quiet_edge = edge_n;
                    x_reload = 1'b1;
                end
            end else if (edge_n == quiet_edge + 1) begin
                act_trx = stg_trx; act_bd = stg_bd; act_rx = stg_rx;
            end else if (edge_n == quiet_edge + 1 + SETTLE) begin
                x_done = 1'b1;
                in_commit = 1'b0;
            end
        end
        if (wr_en) begin
            if (!legal(wr_addr, wr_data)) x_err = 1'b1;
            else if (wr_addr == 2'd0) sh_trx = wr_data[7:0];
            else if (wr_addr == 2'd1) sh_bd = wr_data[12:0];
            else if (wr_addr == 2'd2) sh_rx = wr_data[8:0];
        end
        if (commit && idle_before) begin
            if (sh_rx[3:0] >= sh_rx[8:4]) begin
                x_err = 1'b1;
            end else begin
                stg_trx = sh_trx; stg_bd = sh_bd; stg_rx = sh_rx;
                in_commit = 1'b1;
                quiet_edge = -1;
            end
        end
    endtask

    task automatic compare();
        chk("cfg_trx", 32'(cfg_trx), 32'(act_trx));
        chk("cfg_bdgen", 32'(cfg_bdgen), 32'(act_bd));
        chk("cfg_rx", 32'(cfg_rx), 32'(act_rx));
        chk("tx_hold", 32'(tx_hold), 32'(in_commit));
        chk("busy", 32'(busy), 32'(in_commit));
        chk("done", 32'(done), 32'(x_done));
        chk("err", 32'(err), 32'(x_err));
        chk("bdgen_reload", 32'(bdgen_reload), 32'(x_reload));
        chk("rx_abort", 32'(rx_abort), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic write(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    function automatic logic [15:0] gen_data(input logic [1:0] a);
        logic [15:0] d;
        d = 16'($urandom());
        case (a)
            2'd0: d[5:2] = 4'($urandom_range(4, 9));
            2'd1: begin
                d[4:0] = 5'($urandom_range(2, 31));
                if ($urandom_range(0, 7) == 0) d[12:5] = 8'd0;
            end
            2'd2: d[8:4] = 5'($urandom_range(2, 31));
            default: ;
        endcase
        return d;
    endfunction

    initial begin
        model_reset();
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("rst_trx", 32'(cfg_trx), 32'h20);
        chk("rst_bdgen", 32'(cfg_bdgen), 32'h6D0);
        chk("rst_rx", 32'(cfg_rx), 32'h108);
        chk("rst_hold", 32'(tx_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Divisor 106, osm 16, committed on a quiet line.
        write(2'd1, 16'h0D50);
        commit = 1'b1; cycle(); commit = 1'b0;
        chk("acc_hold", 32'(tx_hold), 32'd1);
        cycle();
        chk("reload_c2", 32'(bdgen_reload), 32'd1);
        cycle();
        chk("div_106", 32'(cfg_bdgen.divisor), 32'd106);
        chk("model_bd", 32'(act_bd), 32'hD50);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("settle_no_done", 32'(done), 32'd0);
        end
        cycle();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_hold_low", 32'(tx_hold), 32'd0);

        // Illegal data_len, then a commit failing the smp_nth/osm cross-check.
        write(2'd0, 16'h0024);
        chk("bad_len_err", 32'(err), 32'd1);
        chk("model_sh_trx", 32'(sh_trx), 32'h20);
        write(2'd2, 16'h008C);
        chk("rx_wr_ok", 32'(err), 32'd0);
        commit = 1'b1; cycle(); commit = 1'b0;
        chk("xchk_err", 32'(err), 32'd1);
        chk("xchk_busy", 32'(busy), 32'd0);
        chk("xchk_rx", 32'(cfg_rx), 32'h108);

        // Commit while TX is busy; a write during the wait must not reach the active set.
        write(2'd2, 16'h00C4);
        tx_busy = 1'b1;
        commit = 1'b1; cycle(); commit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) write(2'd1, 16'h1910);
            else cycle();
            chk("wait_hold", 32'(tx_hold), 32'd1);
            chk("wait_rx", 32'(cfg_rx), 32'h108);
        end
        tx_busy = 1'b0;
        cycle();
        chk("wait_reload", 32'(bdgen_reload), 32'd1);
        cycle();
        chk("wait_rx_new", 32'(cfg_rx), 32'h0C4);
        chk("wait_bd_kept", 32'(cfg_bdgen), 32'hD50);
        repeat (SETTLE) cycle();

        // Reset while waiting for a quiet line.
        tx_busy = 1'b1;
        commit = 1'b1; cycle(); commit = 1'b0;
        cycle();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        chk("rst_wait_hold", 32'(tx_hold), 32'd0);
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_bd", 32'(cfg_bdgen), 32'h6D0);
        chk("rst_wait_rx", 32'(cfg_rx), 32'h108);
        rst = 1'b0;
        tx_busy = 1'b0;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 399) == 0);
            tx_busy = ($urandom_range(0, 99) < 35);
            rx_busy = ($urandom_range(0, 99) < 30);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = gen_data(wr_addr);
            commit  = ($urandom_range(0, 5) == 0);
            cycle();
        end
        rst = 1'b0; wr_en = 1'b0; commit = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
